// File: rtl/pc_fetch_sequencer.sv
// PC and instruction-fetch sequencer: one outstanding imem fetch, issue to decode,
// redirect/squash, halt/resume and an accepted-instruction counter.
module pc_fetch_sequencer #(
  parameter int unsigned          ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]    RESET_VECTOR = '0,
  parameter int unsigned          PC_STEP      = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  output logic [31:0]       inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt_req,
  input  logic              resume,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]        state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic              squash, squash_n;
  logic              imem_req_n;
  logic [ADDR_W-1:0] imem_addr_n;
  logic              inst_valid_n;
  logic [31:0]       inst_out_n;
  logic [ADDR_W-1:0] inst_pc_n;
  logic              halted_n;
  logic [31:0]       fetch_count_n;
  logic [ADDR_W-1:0] target;

  assign target = redirect_addr & ~ADDR_W'(3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_BOOT;
      pc          <= RESET_VECTOR;
      squash      <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      inst_valid  <= 1'b0;
      inst_out    <= '0;
      inst_pc     <= '0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      squash      <= squash_n;
      imem_req    <= imem_req_n;
      imem_addr   <= imem_addr_n;
      inst_valid  <= inst_valid_n;
      inst_out    <= inst_out_n;
      inst_pc     <= inst_pc_n;
      halted      <= halted_n;
      fetch_count <= fetch_count_n;
    end
  end

  // Next-state and next-register values; a redirect always overrides the sequential pc.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    squash_n      = squash;
    imem_req_n    = imem_req;
    imem_addr_n   = imem_addr;
    inst_valid_n  = inst_valid;
    inst_out_n    = inst_out;
    inst_pc_n     = inst_pc;
    halted_n      = halted;
    fetch_count_n = fetch_count;

    case (state)
      S_BOOT: begin
        if (redirect_valid) pc_n = target;
        state_n     = S_FETCH;
        imem_req_n  = 1'b1;
        imem_addr_n = pc_n;
      end

      S_FETCH: begin
        if (!imem_req) begin
          // Gap cycle after a squashed completion: launch the refetch.
          if (redirect_valid) pc_n = target;
          imem_req_n  = 1'b1;
          imem_addr_n = pc_n;
        end else if (imem_ack) begin
          imem_req_n = 1'b0;
          if (squash || redirect_valid) begin
            squash_n = 1'b0;
            if (redirect_valid) pc_n = target;
          end else begin
            inst_out_n   = imem_rdata;
            inst_pc_n    = pc;
            inst_valid_n = 1'b1;
            state_n      = S_ISSUE;
          end
        end else if (redirect_valid) begin
          pc_n     = target;
          squash_n = 1'b1;
        end
      end

      S_ISSUE: begin
        if (inst_ready || redirect_valid) begin
          inst_valid_n = 1'b0;
          if (inst_ready) begin
            fetch_count_n = fetch_count + 32'd1;
            pc_n          = pc + ADDR_W'(PC_STEP);
          end
          if (redirect_valid) pc_n = target;
          if (halt_req) begin
            state_n  = S_HALT;
            halted_n = 1'b1;
          end else begin
            state_n     = S_FETCH;
            imem_req_n  = 1'b1;
            imem_addr_n = pc_n;
          end
        end
      end

      S_HALT: begin
        if (redirect_valid) pc_n = target;
        if (resume) begin
          state_n     = S_FETCH;
          halted_n    = 1'b0;
          imem_req_n  = 1'b1;
          imem_addr_n = pc_n;
        end
      end

      default: state_n = S_BOOT;
    endcase
  end

endmodule
